// File: rtl/pcpi_mem_pkg.sv
// Shared types and constants for the PCPI memory-side responder.
// The optional sticky out-of-range flag is enabled by defining BUS_FAULT_EN.
package pcpi_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} mem_state_t;
  typedef enum logic [1:0] {REG_RAM, REG_LED, REG_SW, REG_OOR} region_t;

  localparam logic [31:0] BUS_ERR_DATA     = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_LED_ADDR     = 32'h0000_2004;
  localparam logic [31:0] DEF_SW_ADDR      = 32'h0000_2008;

  // Register addresses win over the RAM window so they can never be shadowed.
  function automatic region_t decode_region(input logic [29:0] word,
                                            input logic [31:0] led_addr,
                                            input logic [31:0] sw_addr,
                                            input int unsigned ram_words);
    region_t r;
    if (word == led_addr[31:2])                 r = REG_LED;
    else if (word == sw_addr[31:2])             r = REG_SW;
    else if ({2'b00, word} < 32'(ram_words))    r = REG_RAM;
    else                                        r = REG_OOR;
    return r;
  endfunction

endpackage

// File: rtl/pcpi_mem_if.sv
// Request/response bus between the PCPI core (master) and the memory subsystem (slave).
// The master raises mem_valid with address/data/strobes and holds it until the one-cycle
// mem_ready pulse; mem_rdata is meaningful only while mem_ready=1, and mem_wstrb=0 means read.
interface pcpi_mem_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/pcpi_ram_bank.sv
// Single-port synchronous word RAM with per-byte write enables (read-first).
module pcpi_ram_bank #(
  parameter  int RAM_WORDS = 1024,
  localparam int AW        = $clog2(RAM_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/pcpi_mem_subsystem.sv
// Memory-side PCPI responder: word RAM, LED register, synchronised switches.
// Define BUS_FAULT_EN to build the sticky out-of-range bus_fault flag.
module pcpi_mem_subsystem
  import pcpi_mem_pkg::*;
#(
  parameter int          RAM_WORDS   = 1024,
  parameter logic [31:0] LED_ADDR    = DEF_LED_ADDR,
  parameter logic [31:0] SW_ADDR     = DEF_SW_ADDR,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  pcpi_mem_if.slave   bus,
  output logic [15:0] leds,
  input  logic [15:0] sw,
  output logic        bus_fault,
  output mem_state_t  dbg_state
);

  localparam int         AW      = $clog2(RAM_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mem_state_t    r_state, w_next;
  logic [29:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [3:0]    r_cnt;
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic [15:0]   r_leds;
  logic [15:0]   r_sw_meta, r_sw_sync;
  logic          w_accept, w_commit;
  region_t       w_region;
  logic [AW-1:0] w_ram_idx;
  logic [3:0]    w_ram_we;
  logic [31:0]   w_ram_rdata;
  logic          w_unused;

  assign w_accept = (r_state == IDLE) && bus.mem_valid;
  assign w_commit = (r_state == RESP);
  assign w_region = decode_region(r_addr, LED_ADDR, SW_ADDR, RAM_WORDS);
  assign w_unused = ^bus.mem_addr[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.mem_valid) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_leds  <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.mem_addr[31:2];
        r_wdata <= bus.mem_wdata;
        r_wstrb <= bus.mem_wstrb;
        r_cnt   <= WS_LOAD;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_ready <= w_commit;
      if (w_commit && r_wstrb == 4'b0000) begin
        unique case (w_region)
          REG_RAM: r_rdata <= w_ram_rdata;
          REG_LED: r_rdata <= {16'h0000, r_leds};
          REG_SW:  r_rdata <= {16'h0000, r_sw_sync};
          default: r_rdata <= BUS_ERR_DATA;
        endcase
      end
      // Only the low two strobes reach the 16-bit LED register.
      if (w_commit && w_region == REG_LED) begin
        if (r_wstrb[0]) r_leds[7:0]  <= r_wdata[7:0];
        if (r_wstrb[1]) r_leds[15:8] <= r_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // The accepting edge reads straight from the bus so the word is ready by RESP.
  assign w_ram_idx = w_accept ? bus.mem_addr[AW+1:2] : r_addr[AW-1:0];
  assign w_ram_we  = (w_commit && w_region == REG_RAM) ? r_wstrb : 4'b0000;

  pcpi_ram_bank #(.RAM_WORDS(RAM_WORDS)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

`ifdef BUS_FAULT_EN
  logic r_bus_fault;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             r_bus_fault <= 1'b0;
    else if (w_commit && w_region == REG_OOR) r_bus_fault <= 1'b1;
  end
  assign bus_fault = r_bus_fault;
`else
  assign bus_fault = 1'b0;
`endif

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign leds          = r_leds;
  assign dbg_state     = r_state;

endmodule
